pl_scrambler: RTL and testbench



---
 rtl/pl_scrambler_pkg.sv | 55 +++++
 rtl/pl_scrambler_if.sv | 21 ++
 rtl/pl_gold_gen.sv | 38 +++
 rtl/pl_scrambler.sv | 142 ++++++++++++++
 tb/tb_pl_scrambler.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_scrambler_pkg.sv
// pl_pkg: constants, state type and rotation helper shared by the
// PL scrambler and descrambler.
package pl_pkg;

    localparam logic [15:0] HDR_WORD = 16'hFFFF;
    localparam logic [15:0] SUB_WORD = 16'hFFFE;
    localparam int          HDR_LEN  = 4;
    localparam logic [17:0] X_INIT   = 18'h00001;
    localparam logic [17:0] Y_INIT   = 18'h3FFFF;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        TERM
    } pl_state_e;

    // Quadrant rotation of a packed {imag, real} symbol by r*90 degrees.
    function automatic logic [15:0] rot_sym(
        input logic [15:0] sym,
        input logic [1:0]  r
    );
        logic [7:0] i_v;
        logic [7:0] q_v;
        logic [7:0] i_o;
        logic [7:0] q_o;
        i_v = sym[7:0];
        q_v = sym[15:8];
        case (r)
            2'd0: begin
                i_o = i_v;
                q_o = q_v;
            end
            2'd1: begin
                i_o = -q_v;
                q_o = i_v;
            end
            2'd2: begin
                i_o = -i_v;
                q_o = -q_v;
            end
            default: begin
                i_o = q_v;
                q_o = -i_v;
            end
        endcase
        return {q_o, i_o};
    endfunction

    // Clamp -128 to -127 so that negation stays in range.
    function automatic logic [7:0] sat_comp(input logic [7:0] c);
        return (c == 8'h80) ? 8'h81 : c;
    endfunction

endpackage

// File: rtl/pl_scrambler_if.sv
// pl_scrambler_if: valid/ready symbol stream into the PL scrambler.
// master drives symbols, slave accepts them.
interface pl_scrambler_if;

    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/pl_gold_gen.sv
// pl_gold_gen: Gold-sequence x/y registers and 2-bit rotation control.
// Sequences advance only when adv is high; reset is the only reload.
module pl_gold_gen
    import pl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [1:0] rot
);

    logic [17:0] x_q;
    logic [17:0] y_q;
    logic        a_b;
    logic        b_b;
    logic        d_b;

    // Rotation control from the current sequence state.
    always_comb begin
        a_b = x_q[5] ^ x_q[7] ^ x_q[16];
        b_b = y_q[6] ^ y_q[7] ^ (^y_q[16:9]);
        d_b = x_q[1] ^ y_q[1];
        rot = {a_b ^ b_b, d_b};
    end

    // Right-shift both sequences with feedback into bit 17.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q <= X_INIT;
            y_q <= Y_INIT;
        end else if (adv) begin
            x_q <= {x_q[0] ^ x_q[7], x_q[17:1]};
            y_q <= {y_q[0] ^ y_q[5] ^ y_q[7] ^ y_q[10],
                    y_q[17:1]};
        end
    end

endmodule

// File: rtl/pl_scrambler.sv
// pl_scrambler: PL framer emitting 4 header words then FRAME_LEN
// scrambled data words. Option macro: PL_SCR_SAT_EN (clamp -128 inputs).
module pl_scrambler
    import pl_pkg::*;
#(
    parameter int FRAME_LEN = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    pl_scrambler_if.slave      s_if,
    output logic [15:0]        scramble_data,
    output logic               frame_start,
    output logic               underrun,
    output logic               subst
);

    localparam logic [15:0] DATA_LAST = 16'(FRAME_LEN - 1);
    localparam logic [15:0] HDR_LAST  = 16'(HDR_LEN - 1);

    pl_state_e   state_q;
    pl_state_e   state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        s_ready_q;
    logic        fire;
    logic        adv;
    logic [1:0]  rot;
    logic [15:0] sym_raw;
    logic [15:0] sym;
    logic [15:0] rot_word;
    logic        sat_hit;
    logic [15:0] data_d;
    logic        fs_d;
    logic        und_d;
    logic        sub_d;
    logic        ready_d;

    assign s_if.s_ready = s_ready_q;
    assign fire         = s_ready_q & s_if.s_valid;
    assign adv          = (state_q == DATA);

    pl_gold_gen u_gold (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .rot   (rot)
    );

    // Select the accepted symbol or a zero pad, then rotate it.
    always_comb begin
        sym_raw = fire ? s_if.s_data : 16'h0000;
`ifdef PL_SCR_SAT_EN
        sat_hit = (sym_raw[7:0] == 8'h80) ||
                  (sym_raw[15:8] == 8'h80);
        sym     = {sat_comp(sym_raw[15:8]),
                   sat_comp(sym_raw[7:0])};
`else
        sat_hit = 1'b0;
        sym     = sym_raw;
`endif
        rot_word = rot_sym(sym, rot);
    end

    // Frame sequencing and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = 16'h0000;
        fs_d    = 1'b0;
        und_d   = underrun;
        sub_d   = subst;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (en) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
            end
            (state_q == HDR): begin
                data_d = HDR_WORD;
                fs_d   = (cnt_q == '0);
                if (cnt_q == HDR_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            (state_q == DATA): begin
                data_d = rot_word;
                if (rot_word == HDR_WORD) begin
                    data_d = SUB_WORD;
                    sub_d  = 1'b1;
                end
                if (sat_hit) begin
                    sub_d = 1'b1;
                end
                if (!fire) begin
                    und_d = 1'b1;
                end
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = en ? HDR : TERM;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            (state_q == TERM): begin
                data_d  = HDR_WORD;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == DATA);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            s_ready_q     <= 1'b0;
            scramble_data <= 16'h0000;
            frame_start   <= 1'b0;
            underrun      <= 1'b0;
            subst         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            s_ready_q     <= ready_d;
            scramble_data <= data_d;
            frame_start   <= fs_d;
            underrun      <= und_d;
            subst         <= sub_d;
        end
    end

endmodule

// File: tb/tb_pl_scrambler.sv
// tb_pl_scrambler: randomized stimulus against a frame-level reference
// model, plus an independent descrambler on the observed stream.
module tb_pl_scrambler;

    localparam int FL = 4;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] scramble_data;
    logic        frame_start;
    logic        underrun;
    logic        subst;

    pl_scrambler_if sif ();

    pl_scrambler #(
        .FRAME_LEN (FL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .s_if          (sif),
        .scramble_data (scramble_data),
        .frame_start   (frame_start),
        .underrun      (underrun),
        .subst         (subst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // reference model: mode 0 idle, 1 header, 2 data, 3 terminator
    int          m_mode;
    int          m_pos;
    bit [17:0]   mx;
    bit [17:0]   my;
    logic [15:0] e_data;
    logic        e_fs;
    logic        e_und;
    logic        e_sub;
    bit          exp_ready;
    bit          last_acc;
    logic [15:0] last_sym;

    logic [15:0] obs_data;
    logic        obs_fs;
    logic        obs_ready;

    function automatic int gold_r(input bit [17:0] x, input bit [17:0] y);
        bit a;
        bit b;
        bit d;
        a = x[5] ^ x[7] ^ x[16];
        b = y[6] ^ y[7];
        for (int k = 9; k <= 16; k++) b = b ^ y[k];
        d = x[1] ^ y[1];
        return 2 * int'(a ^ b) + int'(d);
    endfunction

    function automatic bit [17:0] next_x(input bit [17:0] x);
        return {x[0] ^ x[7], x[17:1]};
    endfunction

    function automatic bit [17:0] next_y(input bit [17:0] y);
        return {y[0] ^ y[5] ^ y[7] ^ y[10], y[17:1]};
    endfunction

    // multiply (I + jQ) by j^r, wrapping to 8 bits per component
    function automatic logic [15:0] rot_model(input logic [15:0] s, input int r);
        int re;
        int im;
        int t;
        logic [7:0] ro;
        logic [7:0] io;
        re = int'($signed(s[7:0]));
        im = int'($signed(s[15:8]));
        for (int k = 0; k < r; k++) begin
            t  = re;
            re = -im;
            im = t;
        end
        ro = re[7:0];
        io = im[7:0];
        return {io, ro};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        mx     = 18'h00001;
        my     = 18'h3FFFF;
        e_data = 16'h0000;
        e_fs   = 1'b0;
        e_und  = 1'b0;
        e_sub  = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit v, input logic [15:0] d);
        logic [15:0] s;
        logic [15:0] w;
        int r;
        last_acc = 1'b0;
        e_fs     = 1'b0;
        case (m_mode)
            0: begin
                e_data = 16'h0000;
                if (e) begin
                    m_mode = 1;
                    m_pos  = 0;
                end
            end
            1: begin
                e_data = 16'hFFFF;
                e_fs   = (m_pos == 0);
                m_pos++;
                if (m_pos == 4) begin
                    m_mode = 2;
                    m_pos  = 0;
                end
            end
            2: begin
                if (v) begin
                    s        = d;
                    last_acc = 1'b1;
                    last_sym = d;
                end else begin
                    s     = 16'h0000;
                    e_und = 1'b1;
                end
`ifdef PL_SCR_SAT_EN
                if (s[7:0] == 8'h80) begin
                    s[7:0] = 8'h81;
                    e_sub  = 1'b1;
                end
                if (s[15:8] == 8'h80) begin
                    s[15:8] = 8'h81;
                    e_sub   = 1'b1;
                end
`endif
                r = gold_r(mx, my);
                w = rot_model(s, r);
                if (w == 16'hFFFF) begin
                    w     = 16'hFFFE;
                    e_sub = 1'b1;
                end
                e_data = w;
                mx = next_x(mx);
                my = next_y(my);
                m_pos++;
                if (m_pos == FL) begin
                    m_pos  = 0;
                    m_mode = e ? 1 : 3;
                end
            end
            default: begin
                e_data = 16'hFFFF;
                m_mode = 0;
            end
        endcase
    endtask

    // one clock: drive at negedge, step model at posedge, observe at negedge
    task automatic tick(input bit e, input bit v, input logic [15:0] d);
        en          = e;
        sif.s_valid = v;
        sif.s_data  = d;
        obs_ready   = sif.s_ready;
        exp_ready   = (m_mode == 2);
        @(posedge clk);
        model_step(e, v, d);
        @(negedge clk);
        obs_data = scramble_data;
        obs_fs   = frame_start;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        en          = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 16'h0000;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (scramble_data !== 16'h0000 || sif.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data data=%h rdy=%b want 0000/0",
                     scramble_data, sif.s_ready);
        end
        n_chk++;
        if ({frame_start, underrun, subst} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags fs/und/sub=%b want 000",
                     {frame_start, underrun, subst});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 16'h1234);
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL idle_stream t=%0d data=%h/%h fs=%b/%b rdy=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, obs_ready, exp_ready);
            end
        end
    endtask

    task automatic test_first_word();
        logic fs_at2;
        fs_at2 = 1'b0;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b1, 16'h0A05);
            if (i == 2) fs_at2 = obs_fs;
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL first_stream t=%0d data=%h/%h fs=%b/%b rdy=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, obs_ready, exp_ready);
            end
        end
        n_chk++;
        if (fs_at2 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fs got %b want 1", fs_at2);
        end
        n_chk++;
        if (obs_data !== 16'h05F6) begin
            n_fail++;
            $display("FAIL first_word got %h want 05F6", obs_data);
        end
    endtask

    task automatic test_continuous();
        logic [15:0] sent[$];
        logic [15:0] d;
        logic [15:0] rec;
        logic [15:0] want;
        bit [17:0]   dx;
        bit [17:0]   dy;
        int hdr_left;
        int data_left;
        int r;
        dx        = 18'h00001;
        dy        = 18'h3FFFF;
        hdr_left  = 0;
        data_left = 0;
        do_reset();
        for (int i = 0; i < 1 + 3 * (4 + FL); i++) begin
            d = 16'($urandom);
            tick(1'b1, 1'b1, d);
            if (last_acc) sent.push_back(last_sym);
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL cont_stream t=%0d data=%h/%h fs=%b/%b rdy=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, obs_ready, exp_ready);
            end
            if (obs_fs === 1'b1) begin
                hdr_left = 3;
            end else if (hdr_left > 0) begin
                hdr_left--;
                if (hdr_left == 0) data_left = FL;
            end else if (data_left > 0) begin
                data_left--;
                r   = gold_r(dx, dy);
                rec = rot_model(obs_data, (4 - r) % 4);
                dx  = next_x(dx);
                dy  = next_y(dy);
                want = (sent.size() > 0) ? sent.pop_front() : 16'hxxxx;
                if (obs_data !== 16'hFFFE) begin
                    n_chk++;
                    if (rec !== want) begin
                        n_fail++;
                        $display("FAIL descramble t=%0d got %h want %h", i, rec, want);
                    end
                end
            end
        end
    endtask

    task automatic test_underrun();
        bit did_pad;
        bit pad;
        int fs_n;
        int fs2_t;
        did_pad = 1'b0;
        fs_n    = 0;
        fs2_t   = -1;
        do_reset();
        for (int i = 1; i <= 1 + 2 * (4 + FL); i++) begin
            pad = (m_mode == 2 && m_pos == 1 && !did_pad);
            tick(1'b1, !pad, 16'($urandom));
            if (obs_fs === 1'b1) begin
                fs_n++;
                if (fs_n == 2) fs2_t = i;
            end
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL under_stream t=%0d data=%h/%h fs=%b/%b und=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, underrun, e_und);
            end
            if (pad) begin
                did_pad = 1'b1;
                n_chk++;
                if (obs_data !== 16'h0000 || underrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pad_slot data=%h und=%b want 0000/1",
                             obs_data, underrun);
                end
            end
        end
        n_chk++;
        if (fs2_t != 2 + 4 + FL) begin
            n_fail++;
            $display("FAIL next_header at t=%0d want %0d", fs2_t, 2 + 4 + FL);
        end
    endtask

    task automatic test_en_drop();
        logic [15:0] outs[1:13];
        do_reset();
        for (int i = 1; i <= 13; i++) begin
            tick(i <= 7, 1'b1, 16'($urandom));
            outs[i] = obs_data;
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL drop_stream t=%0d data=%h/%h fs=%b/%b rdy=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, obs_ready, exp_ready);
            end
        end
        n_chk++;
        if (outs[10] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL term_word got %h want FFFF", outs[10]);
        end
        n_chk++;
        if ({outs[11], outs[12], outs[13]} !== 48'h0) begin
            n_fail++;
            $display("FAIL idle_after %h %h %h want 0000", outs[11], outs[12], outs[13]);
        end
    endtask

    task automatic test_subst();
        bit done;
        bit hit;
        done = 1'b0;
        do_reset();
        for (int i = 0; i < 80 && !done; i++) begin
            hit = (m_mode == 2 && gold_r(mx, my) == 0);
            if (hit) begin
                n_chk++;
                if (subst !== 1'b0) begin
                    n_fail++;
                    $display("FAIL subst_early got %b want 0", subst);
                end
            end
            tick(1'b1, 1'b1, hit ? 16'hFFFF : 16'h0102);
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL subst_stream t=%0d data=%h/%h sub=%b/%b",
                         i, obs_data, e_data, subst, e_sub);
            end
            if (hit) begin
                done = 1'b1;
                n_chk++;
                if (obs_data !== 16'hFFFE || subst !== 1'b1) begin
                    n_fail++;
                    $display("FAIL subst_word data=%h sub=%b want FFFE/1",
                             obs_data, subst);
                end
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL subst_slot no R=0 slot within budget");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 16'($urandom));
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        n_chk++;
        if (scramble_data !== 16'h0000 || sif.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset data=%h rdy=%b want 0000/0",
                     scramble_data, sif.s_ready);
        end
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) tick(1'b1, 1'b1, 16'h0A05);
        n_chk++;
        if (obs_data !== 16'h05F6) begin
            n_fail++;
            $display("FAIL reseed_word got %h want 05F6", obs_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 120; i++) begin
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                 16'($urandom));
            n_chk++;
            if (obs_data !== e_data || obs_fs !== e_fs || obs_ready !== exp_ready ||
                underrun !== e_und || subst !== e_sub) begin
                n_fail++;
                $display("FAIL rand_stream t=%0d data=%h/%h fs=%b/%b rdy=%b/%b",
                         i, obs_data, e_data, obs_fs, e_fs, obs_ready, exp_ready);
            end
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        en          = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 16'h0000;
        model_reset();
        @(negedge clk);
        test_reset();
        test_first_word();
        test_continuous();
        test_underrun();
        test_en_drop();
        test_subst();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
